// File: rtl/alu_pkg.sv
// Shared ALU definitions: opSel encodings and default widths used by the ALU
// and by every block that borrows it.
package alu_pkg;
    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_SEL_WIDTH  = 4;

    localparam logic [ALU_SEL_WIDTH-1:0] OP_ADD = 4'd0;
    localparam logic [ALU_SEL_WIDTH-1:0] OP_SUB = 4'd1;
    localparam logic [ALU_SEL_WIDTH-1:0] OP_AND = 4'd2;
    localparam logic [ALU_SEL_WIDTH-1:0] OP_OR  = 4'd3;
    localparam logic [ALU_SEL_WIDTH-1:0] OP_SLT = 4'd4;
    localparam logic [ALU_SEL_WIDTH-1:0] OP_XOR = 4'd5;
    localparam logic [ALU_SEL_WIDTH-1:0] OP_NOR = 4'd6;
    localparam logic [ALU_SEL_WIDTH-1:0] OP_SLL = 4'd7;
    localparam logic [ALU_SEL_WIDTH-1:0] OP_SLR = 4'd8;
endpackage

// File: rtl/alu.sv
// Shared combinational ALU of the EX stage. Shifts use shamt on op1; SLT is
// a signed compare. zero flags an all-zero result.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int SEL_WIDTH  = ALU_SEL_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [SEL_WIDTH-1:0]  opsel,
    input  logic [4:0]            shamt,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);
    always_comb begin
        result = '0;
        case (opsel)
            SEL_WIDTH'(OP_ADD): result = op1 + op2;
            SEL_WIDTH'(OP_SUB): result = op1 - op2;
            SEL_WIDTH'(OP_AND): result = op1 & op2;
            SEL_WIDTH'(OP_OR):  result = op1 | op2;
            SEL_WIDTH'(OP_SLT): result = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            SEL_WIDTH'(OP_XOR): result = op1 ^ op2;
            SEL_WIDTH'(OP_NOR): result = ~(op1 | op2);
            SEL_WIDTH'(OP_SLL): result = op1 << shamt;
            SEL_WIDTH'(OP_SLR): result = op1 >> shamt;
            default:            result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the shared ALU for every
// arithmetic step; product is the low DATA_WIDTH bits of a*b.
//
//  state | meaning
//  IDLE  | waiting for start; ALU released
//  ADD   | acc <= acc + mcand (current multiplier bit set)
//  SHL   | mcand <= mcand << 1
//  SHR   | mplier <= mplier >> 1; finish once it reaches zero
//  DONE  | product valid, done pulse
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int SEL_WIDTH  = ALU_SEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product,
    output logic                  alu_own,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [SEL_WIDTH-1:0]  alu_opsel,
    output logic [4:0]            alu_shamt,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;

    // A flush freezes the datapath so product keeps the partial acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= a;
                        mplier <= b;
                        if (b == '0)     state <= S_DONE;
                        else if (b[0])   state <= S_ADD;
                        else             state <= S_SHL;
                    end
                end
                S_ADD: begin
                    acc   <= alu_result;
                    state <= S_SHL;
                end
                S_SHL: begin
                    mcand <= alu_result;
                    state <= S_SHR;
                end
                S_SHR: begin
                    mplier <= alu_result;
                    if (alu_zero)           state <= S_DONE;
                    else if (alu_result[0]) state <= S_ADD;
                    else                    state <= S_SHL;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign product = acc;

    always_comb begin
        alu_own   = 1'b0;
        alu_op1   = '0;
        alu_op2   = '0;
        alu_opsel = '0;
        alu_shamt = '0;
        case (state)
            S_ADD: begin
                alu_own   = 1'b1;
                alu_op1   = acc;
                alu_op2   = mcand;
                alu_opsel = SEL_WIDTH'(OP_ADD);
            end
            S_SHL: begin
                alu_own   = 1'b1;
                alu_op1   = mcand;
                alu_opsel = SEL_WIDTH'(OP_SLL);
                alu_shamt = 5'd1;
            end
            S_SHR: begin
                alu_own   = 1'b1;
                alu_op1   = mplier;
                alu_opsel = SEL_WIDTH'(OP_SLR);
                alu_shamt = 5'd1;
            end
            default: ;
        endcase
    end
endmodule
